// File: rtl/serial_add_ctrl.sv
// Serial WIDTH-bit adder: one 4-bit ripple-carry adder reused once per nibble, LSB nibble first.
// Optional signed-overflow output enabled by defining SERIAL_ADD_OVF_EN.
module serial_add_ctrl #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             busy
`ifdef SERIAL_ADD_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int NIBBLES = WIDTH / 4;
   localparam int CNT_W   = $clog2(NIBBLES);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   a_reg_q, a_reg_d;
   logic [WIDTH-1:0]   b_reg_q, b_reg_d;
   logic [WIDTH-1:0]   sum_q, sum_d;
   logic               cout_q, cout_d;
   logic               carry_q, carry_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [4:0]         adder_res;

`ifdef SERIAL_ADD_OVF_EN
   logic a_msb_q, a_msb_d;
   logic b_msb_q, b_msb_d;
   logic ovf_q, ovf_d;
`endif

   function automatic logic [4:0] ripple4(input logic [3:0] x, input logic [3:0] y,
                                          input logic ci);
      logic [3:0] s;
      logic       c;
      c = ci;
      for (int i = 0; i < 4; i++) begin
         s[i] = x[i] ^ y[i] ^ c;
         c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
      end
      return {c, s};
   endfunction

   // The shared adder sees only registered operands, so no input-to-output path exists.
   always_comb begin
      adder_res = ripple4(a_reg_q[3:0], b_reg_q[3:0], carry_q);
   end

   always_comb begin
      state_d = state_q;
      a_reg_d = a_reg_q;
      b_reg_d = b_reg_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      carry_d = carry_q;
      cnt_d   = cnt_q;
`ifdef SERIAL_ADD_OVF_EN
      a_msb_d = a_msb_q;
      b_msb_d = b_msb_q;
      ovf_d   = ovf_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_reg_d = a;
               b_reg_d = b;
               carry_d = cin;
               cnt_d   = '0;
`ifdef SERIAL_ADD_OVF_EN
               a_msb_d = a[WIDTH-1];
               b_msb_d = b[WIDTH-1];
`endif
               state_d = RUN;
            end
         end
         RUN: begin
            sum_d   = {adder_res[3:0], sum_q[WIDTH-1:4]};
            carry_d = adder_res[4];
            a_reg_d = {4'b0000, a_reg_q[WIDTH-1:4]};
            b_reg_d = {4'b0000, b_reg_q[WIDTH-1:4]};
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(NIBBLES - 1)) begin
               cout_d  = adder_res[4];
`ifdef SERIAL_ADD_OVF_EN
               ovf_d   = (a_msb_q == b_msb_q) && (adder_res[3] != a_msb_q);
`endif
               state_d = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_reg_q <= '0;
         b_reg_q <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         a_reg_q <= a_reg_d;
         b_reg_q <= b_reg_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         carry_q <= carry_d;
         cnt_q   <= cnt_d;
      end
   end

`ifdef SERIAL_ADD_OVF_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_msb_q <= 1'b0;
         b_msb_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         a_msb_q <= a_msb_d;
         b_msb_q <= b_msb_d;
         ovf_q   <= ovf_d;
      end
   end

   assign ovf = ovf_q;
`endif

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q == RUN) || (state_q == DONE);
   assign sum       = sum_q;
   assign cout      = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed self-checking bench for serial_add_ctrl (WIDTH=16); ovf checks when SERIAL_ADD_OVF_EN is defined.
module tb_serial_add_ctrl;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] a;
   logic [15:0] b;
   logic        cin;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] sum;
   logic        cout;
   logic        busy;
`ifdef SERIAL_ADD_OVF_EN
   logic        ovf;
`endif

   int compareCount  = 0;
   int mismatchCount = 0;
   int cycleCount    = 0;
   int acceptCycle   = 0;

   serial_add_ctrl #(.WIDTH(16)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .busy      (busy)
`ifdef SERIAL_ADD_OVF_EN
      ,
      .ovf       (ovf)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cycleCount <= cycleCount + 1;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      compareCount++;
      if (got !== exp) begin
         mismatchCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Present an operand pair, wait for the accept edge, then scramble the inputs.
   task automatic applyStimulus(input logic [15:0] ta, input logic [15:0] tb, input logic tcin);
      bit accepted;
      accepted = 1'b0;
      in_valid = 1'b1;
      a        = ta;
      b        = tb;
      cin      = tcin;
      for (int n = 0; n < 50; n++) begin
         accepted = in_ready;
         @(posedge clk);
         #1;
         if (accepted) break;
      end
      if (!accepted) checkOutput("acceptTimeout", 32'd0, 32'd1);
      acceptCycle = cycleCount;
      in_valid = 1'b0;
      a        = 16'(($urandom));
      b        = 16'(($urandom));
      cin      = 1'($urandom);
   endtask

   // Wait for out_valid and check latency plus the result.
   task automatic waitResult(input string tag, input logic [15:0] expSum, input logic expCout);
      int lat;
      lat = 0;
      checkOutput({tag, ".busyRun"}, 32'(busy), 32'd1);
      while (!out_valid && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
      checkOutput({tag, ".latency"}, 32'(lat), 32'd4);
      checkOutput({tag, ".sum"}, 32'(sum), 32'(expSum));
      checkOutput({tag, ".cout"}, 32'(cout), 32'(expCout));
      checkOutput({tag, ".inReadyDone"}, 32'(in_ready), 32'd0);
   endtask

   initial begin
      int prevAccept;
      logic [15:0] heldSum;
      logic        heldCout;

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      a         = '0;
      b         = '0;
      cin       = 1'b0;
      out_ready = 1'b1;
      #12;
      checkOutput("reset.inReady", 32'(in_ready), 32'd1);
      checkOutput("reset.outValid", 32'(out_valid), 32'd0);
      checkOutput("reset.busy", 32'(busy), 32'd0);
      checkOutput("reset.sum", 32'(sum), 32'd0);
      checkOutput("reset.cout", 32'(cout), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      applyStimulus(16'h000A, 16'h0002, 1'b0);
      waitResult("add0A02", 16'h000C, 1'b0);

      applyStimulus(16'hFFFF, 16'h0001, 1'b0);
      waitResult("addFFFF01", 16'h0000, 1'b1);

      applyStimulus(16'h1234, 16'h4321, 1'b1);
      waitResult("add1234", 16'h5556, 1'b0);
      prevAccept = acceptCycle;
      applyStimulus(16'h8000, 16'h8000, 1'b0);
      checkOutput("minII", 32'(acceptCycle - prevAccept), 32'd6);
      waitResult("add8000", 16'h0000, 1'b1);

      // Backpressure: result must stall in DONE while new operands wait.
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      applyStimulus(16'h1111, 16'h2222, 1'b0);
      waitResult("bp", 16'h3333, 1'b0);
      heldSum  = sum;
      heldCout = cout;
      in_valid = 1'b1;
      a        = 16'h0003;
      b        = 16'h0004;
      cin      = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         checkOutput("bp.outValid", 32'(out_valid), 32'd1);
         checkOutput("bp.sumHeld", 32'(sum), 32'(heldSum));
         checkOutput("bp.coutHeld", 32'(cout), 32'(heldCout));
         checkOutput("bp.inReady", 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("bp.releaseInReady", 32'(in_ready), 32'd1);
      checkOutput("bp.releaseOutValid", 32'(out_valid), 32'd0);
      applyStimulus(16'h0003, 16'h0004, 1'b0);
      waitResult("bpQueued", 16'h0007, 1'b0);

      // Asynchronous reset mid-RUN.
      applyStimulus(16'h5555, 16'h5555, 1'b0);
      @(posedge clk);
      #1;
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("asyncRst.outValid", 32'(out_valid), 32'd0);
      checkOutput("asyncRst.busy", 32'(busy), 32'd0);
      checkOutput("asyncRst.inReady", 32'(in_ready), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      applyStimulus(16'h00FF, 16'h0001, 1'b0);
      waitResult("postRst", 16'h0100, 1'b0);

`ifdef SERIAL_ADD_OVF_EN
      applyStimulus(16'h7FFF, 16'h0001, 1'b0);
      waitResult("ovf7FFF", 16'h8000, 1'b0);
      checkOutput("ovf7FFF.ovf", 32'(ovf), 32'd1);
      applyStimulus(16'hFFFF, 16'h0001, 1'b0);
      waitResult("ovfFFFF", 16'h0000, 1'b1);
      checkOutput("ovfFFFF.ovf", 32'(ovf), 32'd0);
      applyStimulus(16'h8000, 16'h8000, 1'b0);
      waitResult("ovf8000", 16'h0000, 1'b1);
      checkOutput("ovf8000.ovf", 32'(ovf), 32'd1);
`endif

      @(posedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
      $finish;
   end

endmodule
